// File: rtl/ehl_ahb_pkg.sv
// Shared AHB encodings and input-stage state type for the AHB matrix.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: HTRANS/HRESP codes, input-stage state encoding, captured
// address-phase struct.
package ehl_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // IDLE : no data phase outstanding
  // PEND : address phase held, waiting for the path to accept it
  // DATA : data phase in progress on path r_sel
  // ERR1/ERR2 : two-cycle default-slave ERROR response
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEND = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  // Address-phase bundle, both as driven to the paths and as captured.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } aphase_t;

endpackage

// File: rtl/ehl_ahb_addr_decoder.sv
// Address decoder: address -> one-hot slave select plus no-match flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_addr (32) in; o_sel (SNUM, one-hot) out; o_nomatch out.
// Overlapping windows resolve to the lowest slave index.
module ehl_ahb_addr_decoder #(
  parameter int                     SNUM  = 4,
  parameter logic [SNUM*32-1:0]     SBASE = {SNUM{32'h0}},
  parameter logic [SNUM*32-1:0]     SMASK = {SNUM{32'hF000_0000}}
) (
  input  logic [31:0]      i_addr,
  output logic [SNUM-1:0]  o_sel,
  output logic             o_nomatch
);

  always_comb begin
    o_sel     = '0;
    o_nomatch = 1'b1;
    // Walk from highest to lowest so the lowest matching index is the last
    // one written and therefore wins.
    for (int j = SNUM - 1; j >= 0; j--) begin
      if ((i_addr & SMASK[j*32 +: 32]) == SBASE[j*32 +: 32]) begin
        o_sel     = '0;
        o_sel[j]  = 1'b1;
        o_nomatch = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ehl_ahb_matrix_in.sv
// Per-master AHB matrix input stage: decode, forward or hold the address
// phase, return the selected path's response; default slave on no match.
// Latency: zero added waits when the path is ready; a held address phase
// costs one cycle plus the path stall.
// Backpressure: om_hready follows the selected path in DATA, is low while
// holding (PEND) and during the first ERROR cycle.
// Ports: hclk/hreset; im_* master address/data phase in; om_* response to
// master; os_* address phase to paths (os_htrans per path); is_* per-path
// response in.
module ehl_ahb_matrix_in
  import ehl_ahb_pkg::*;
#(
  parameter int                 SNUM  = 4,
  parameter logic [SNUM*32-1:0] SBASE = {SNUM{32'h0}},
  parameter logic [SNUM*32-1:0] SMASK = {SNUM{32'hF000_0000}}
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [31:0]          im_haddr,
  input  logic [1:0]           im_htrans,
  input  logic                 im_hwrite,
  input  logic [2:0]           im_hsize,
  input  logic [2:0]           im_hburst,
  input  logic [3:0]           im_hprot,
  input  logic [31:0]          im_hwdata,
  output logic [31:0]          om_hrdata,
  output logic                 om_hready,
  output logic [1:0]           om_hresp,
  output logic [31:0]          os_haddr,
  output logic [SNUM*2-1:0]    os_htrans,
  output logic                 os_hwrite,
  output logic [2:0]           os_hsize,
  output logic [2:0]           os_hburst,
  output logic [3:0]           os_hprot,
  output logic [31:0]          os_hwdata,
  input  logic [SNUM*32-1:0]   is_hrdata,
  input  logic [SNUM-1:0]      is_hready,
  input  logic [SNUM*2-1:0]    is_hresp
);

  localparam int SW = (SNUM > 1) ? $clog2(SNUM) : 1;

  state_t          r_state;
  state_t          w_next_state;
  logic [SW-1:0]   r_sel;        // path owning the held/data phase
  logic [SW-1:0]   w_next_sel;
  logic [SW-1:0]   r_last_sel;   // last path given a NONSEQ/SEQ, target of BUSY
  logic [SW-1:0]   w_next_last;
  aphase_t         r_ap;         // captured address phase for PEND
  aphase_t         w_im_ap;
  aphase_t         w_ap;         // address phase currently driven to paths
  logic            w_capture;

  logic [SNUM-1:0] w_dec_sel;
  logic            w_dec_nomatch;
  logic [SW-1:0]   w_dec_idx;
  logic [SNUM*2-1:0] w_trans;

  ehl_ahb_addr_decoder #(
    .SNUM  (SNUM),
    .SBASE (SBASE),
    .SMASK (SMASK)
  ) u_dec (
    .i_addr    (im_haddr),
    .o_sel     (w_dec_sel),
    .o_nomatch (w_dec_nomatch)
  );

  // One-hot to index; no match is handled separately as the default slave.
  always_comb begin
    w_dec_idx = '0;
    for (int i = 0; i < SNUM; i++) begin
      if (w_dec_sel[i]) w_dec_idx = SW'(i);
    end
  end

  assign w_im_ap = '{addr: im_haddr, trans: im_htrans, write: im_hwrite,
                     size: im_hsize, burst: im_hburst, prot: im_hprot};

  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_last  = r_last_sel;
    w_capture    = 1'b0;
    w_ap         = w_im_ap;
    w_trans      = '0;
    om_hready    = 1'b1;
    om_hresp     = HRESP_OKAY;
    om_hrdata    = '0;

    case (r_state)
      S_PEND: begin
        om_hready = 1'b0;
        w_ap      = r_ap;
        w_trans[r_sel*2 +: 2] = r_ap.trans;
        if (is_hready[r_sel]) w_next_state = S_DATA;
      end
      S_DATA: begin
        om_hready = is_hready[r_sel];
        om_hresp  = is_hresp[r_sel*2 +: 2];
        om_hrdata = is_hrdata[r_sel*32 +: 32];
      end
      S_ERR1: begin
        om_hready    = 1'b0;
        om_hresp     = HRESP_ERROR;
        w_next_state = S_ERR2;
      end
      S_ERR2: begin
        om_hresp = HRESP_ERROR;
      end
      default: ;
    endcase

    // A master address phase is only valid when the master sees hready high;
    // in DATA/ERR2 this pipelines the next phase into the completing cycle.
    if (om_hready) begin
      w_next_state = S_IDLE;
      case (im_htrans)
        HTRANS_NONSEQ, HTRANS_SEQ: begin
          if (w_dec_nomatch) begin
            w_next_state = S_ERR1;
          end else begin
            w_trans[w_dec_idx*2 +: 2] = im_htrans;
            w_next_sel  = w_dec_idx;
            w_next_last = w_dec_idx;
            if (is_hready[w_dec_idx]) begin
              w_next_state = S_DATA;
            end else begin
              w_capture    = 1'b1;
              w_next_state = S_PEND;
            end
          end
        end
        HTRANS_BUSY: begin
          // Keeps the burst context on the path; no data phase follows here.
          w_trans[r_last_sel*2 +: 2] = HTRANS_BUSY;
        end
        default: ;
      endcase
    end

    // Nothing is offered to any path while reset is held.
    if (hreset) w_trans = '0;
  end

  assign os_haddr  = w_ap.addr;
  assign os_hwrite = w_ap.write;
  assign os_hsize  = w_ap.size;
  assign os_hburst = w_ap.burst;
  assign os_hprot  = w_ap.prot;
  assign os_htrans = w_trans;
  assign os_hwdata = im_hwdata;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_last_sel <= '0;
      r_ap       <= '0;
    end else begin
      r_state    <= w_next_state;
      r_sel      <= w_next_sel;
      r_last_sel <= w_next_last;
      if (w_capture) r_ap <= w_im_ap;
    end
  end

endmodule

// File: tb/tb_ehl_ahb_matrix_in.sv
module tb_ehl_ahb_matrix_in;
  import ehl_ahb_pkg::*;

  localparam int SNUM = 4;
  localparam logic [SNUM*32-1:0] SBASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [SNUM*32-1:0] SMASK = {SNUM{32'hF000_0000}};

  logic                hclk = 1'b0;
  logic                hreset;
  logic [31:0]         im_haddr;
  logic [1:0]          im_htrans;
  logic                im_hwrite;
  logic [2:0]          im_hsize;
  logic [2:0]          im_hburst;
  logic [3:0]          im_hprot;
  logic [31:0]         im_hwdata;
  logic [31:0]         om_hrdata;
  logic                om_hready;
  logic [1:0]          om_hresp;
  logic [31:0]         os_haddr;
  logic [SNUM*2-1:0]   os_htrans;
  logic                os_hwrite;
  logic [2:0]          os_hsize;
  logic [2:0]          os_hburst;
  logic [3:0]          os_hprot;
  logic [31:0]         os_hwdata;
  logic [SNUM*32-1:0]  is_hrdata;
  logic [SNUM-1:0]     is_hready;
  logic [SNUM*2-1:0]   is_hresp;

  int n_checks = 0;
  int n_errors = 0;

  ehl_ahb_matrix_in #(.SNUM(SNUM), .SBASE(SBASE), .SMASK(SMASK)) dut (
    .hclk(hclk), .hreset(hreset),
    .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
    .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot),
    .im_hwdata(im_hwdata),
    .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
    .os_haddr(os_haddr), .os_htrans(os_htrans), .os_hwrite(os_hwrite),
    .os_hsize(os_hsize), .os_hburst(os_hburst), .os_hprot(os_hprot),
    .os_hwdata(os_hwdata),
    .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
  );

  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are then applied.
  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic master(input logic [1:0] t, input logic [31:0] a, input logic w);
    im_htrans = t;
    im_haddr  = a;
    im_hwrite = w;
  endtask

  initial begin
    hreset    = 1'b1;
    im_haddr  = '0;
    im_htrans = HTRANS_IDLE;
    im_hwrite = 1'b0;
    im_hsize  = 3'd2;
    im_hburst = 3'd0;
    im_hprot  = 4'h3;
    im_hwdata = '0;
    is_hrdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    is_hready = '1;
    is_hresp  = '0;

    // Reset state
    next_cycle(); next_cycle(); #2;
    chk("rst_hready", 32'(om_hready), 32'd1);
    chk("rst_hresp",  32'(om_hresp),  32'd0);
    chk("rst_hrdata", om_hrdata,      32'd0);
    chk("rst_htrans", 32'(os_htrans), 32'd0);
    next_cycle();
    hreset = 1'b0;

    // Zero-wait read to slave 1
    master(HTRANS_NONSEQ, 32'h1000_0004, 1'b0); #2;
    chk("zw_htrans", 32'(os_htrans), 32'h08);
    chk("zw_haddr",  os_haddr,       32'h1000_0004);
    next_cycle();
    master(HTRANS_IDLE, 32'h0, 1'b0); #2;
    chk("zw_hrdata", om_hrdata,      32'hCAFE_0001);
    chk("zw_hready", 32'(om_hready), 32'd1);
    chk("zw_hresp",  32'(om_hresp),  32'd0);
    chk("zw_idle",   32'(os_htrans), 32'd0);

    // Pending write to slave 2: path stalls 3 cycles of om_hready=0
    next_cycle();
    is_hready[2] = 1'b0;
    master(HTRANS_NONSEQ, 32'h2000_0010, 1'b1); #2;
    chk("pd_c0_htrans", 32'(os_htrans), 32'h20);
    chk("pd_c0_hready", 32'(om_hready), 32'd1);
    next_cycle();
    master(HTRANS_IDLE, 32'h0000_0040, 1'b0);
    im_hwdata = 32'h1234_5678; #2;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        is_hready[2] = 1'b1; #1;
      end
      chk("pd_hready", 32'(om_hready), 32'd0);
      chk("pd_haddr",  os_haddr,       32'h2000_0010);
      chk("pd_htrans", 32'(os_htrans), 32'h20);
      chk("pd_hwrite", 32'(os_hwrite), 32'd1);
      next_cycle(); #2;
    end
    chk("pd_data_hready", 32'(om_hready), 32'd1);
    chk("pd_data_hwdata", os_hwdata,      32'h1234_5678);
    chk("pd_data_hrdata", om_hrdata,      32'hCAFE_0002);

    // Unmapped address -> two-cycle ERROR, nothing forwarded
    next_cycle();
    master(HTRANS_NONSEQ, 32'hF000_0000, 1'b0); #2;
    chk("um_c0_htrans", 32'(os_htrans), 32'd0);
    next_cycle();
    master(HTRANS_IDLE, 32'h0, 1'b0); #2;
    chk("um_e1_hready", 32'(om_hready), 32'd0);
    chk("um_e1_hresp",  32'(om_hresp),  32'd1);
    chk("um_e1_htrans", 32'(os_htrans), 32'd0);
    next_cycle(); #2;
    chk("um_e2_hready", 32'(om_hready), 32'd1);
    chk("um_e2_hresp",  32'(om_hresp),  32'd1);
    next_cycle(); #2;
    chk("um_done_hresp", 32'(om_hresp), 32'd0);

    // Back-to-back slave 0 then slave 3, no bubble
    master(HTRANS_NONSEQ, 32'h0000_0100, 1'b0); #2;
    chk("bb_s0_htrans", 32'(os_htrans), 32'h02);
    next_cycle();
    master(HTRANS_NONSEQ, 32'h3000_0000, 1'b0); #2;
    chk("bb_s0_hrdata", om_hrdata,      32'hCAFE_0000);
    chk("bb_s3_htrans", 32'(os_htrans), 32'h80);
    chk("bb_s3_haddr",  os_haddr,       32'h3000_0000);
    next_cycle();
    master(HTRANS_IDLE, 32'h0, 1'b0); #2;
    chk("bb_s3_hrdata", om_hrdata,      32'hCAFE_0003);
    chk("bb_s3_hready", 32'(om_hready), 32'd1);

    // BUSY goes to last selected path with zero-wait OKAY, then SEQ
    next_cycle();
    master(HTRANS_NONSEQ, 32'h1000_0000, 1'b0); #2;
    next_cycle();
    master(HTRANS_BUSY, 32'h1000_0004, 1'b0); #2;
    chk("bz_htrans", 32'(os_htrans), 32'h04);
    next_cycle(); #2;
    chk("bz_idle_htrans", 32'(os_htrans), 32'h04);
    chk("bz_idle_hready", 32'(om_hready), 32'd1);
    chk("bz_idle_hresp",  32'(om_hresp),  32'd0);
    next_cycle();
    master(HTRANS_SEQ, 32'h1000_0004, 1'b0); #2;
    chk("sq_htrans", 32'(os_htrans), 32'h0C);
    next_cycle();
    master(HTRANS_IDLE, 32'h0, 1'b0); #2;
    chk("sq_hrdata", om_hrdata, 32'hCAFE_0001);

    // Slave ERROR pass-through with a wait state
    next_cycle();
    master(HTRANS_NONSEQ, 32'h0000_0200, 1'b0); #2;
    next_cycle();
    master(HTRANS_IDLE, 32'h0, 1'b0);
    is_hready[0] = 1'b0;
    is_hresp[1:0] = HRESP_ERROR; #2;
    chk("se_w_hready", 32'(om_hready), 32'd0);
    chk("se_w_hresp",  32'(om_hresp),  32'd1);
    next_cycle();
    is_hready[0] = 1'b1; #2;
    chk("se_d_hready", 32'(om_hready), 32'd1);
    chk("se_d_hresp",  32'(om_hresp),  32'd1);
    next_cycle();
    is_hresp = '0;

    // Reset asserted while holding a pending transfer
    is_hready[1] = 1'b0;
    master(HTRANS_NONSEQ, 32'h1000_0000, 1'b0); #2;
    next_cycle(); #2;
    chk("rp_pend_hready", 32'(om_hready), 32'd0);
    chk("rp_pend_htrans", 32'(os_htrans), 32'h08);
    hreset = 1'b1; #1;
    chk("rp_rst_hready", 32'(om_hready), 32'd1);
    chk("rp_rst_htrans", 32'(os_htrans), 32'd0);
    chk("rp_rst_hresp",  32'(om_hresp),  32'd0);
    next_cycle();
    hreset = 1'b0;
    is_hready = '1;
    master(HTRANS_IDLE, 32'h0, 1'b0);
    next_cycle(); #2;
    chk("rp_after_hready", 32'(om_hready), 32'd1);
    chk("rp_after_hrdata", om_hrdata,      32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ehl_ahb_matrix_in.md
Name: ehl_ahb_matrix_in

Overview:
Per-master input stage of the AHB matrix: the master-facing counterpart of the per-slave output stage. It accepts one AHB master's address phase and decodes it to one of SNUM slave paths, then forwards the transfer to that path. If the path is not ready, it holds the transfer in a register. It routes the selected path's hrdata/hready/hresp back to the master and answers unmapped addresses with a built-in default-slave ERROR.

Parameters:
SNUM, 4, number of slave paths (output stages) reachable from this master.
SBASE, {SNUM{32'h0}}, packed SNUM*32 slave base addresses; slave j occupies bits [j*32+:32].
SMASK, {SNUM{32'hF000_0000}}, packed SNUM*32 decode masks; slave j matches when (haddr & mask_j) == base_j.

Ports:
hclk  in  1  clock
hreset  in  1  asynchronous active-high reset
im_haddr  in  32  master address
im_htrans  in  2  master transfer type
im_hwrite  in  1  master write
im_hsize  in  3  master size
im_hburst  in  3  master burst
im_hprot  in  4  master protection
im_hwdata  in  32  master write data
om_hrdata  out  32  read data to master
om_hready  out  1  ready to master
om_hresp  out  2  response to master
os_haddr  out  32  address, shared by all paths
os_htrans  out  SNUM*2  per-path htrans; IDLE on unselected paths
os_hwrite  out  1  shared
os_hsize  out  3  shared
os_hburst  out  3  shared
os_hprot  out  4  shared
os_hwdata  out  32  im_hwdata broadcast, unregistered
is_hrdata  in  SNUM*32  per-path read data
is_hready  in  SNUM  per-path ready (address accepted / data phase done)
is_hresp  in  SNUM*2  per-path response

Behaviour:
- Clock and reset: one clock hclk. hreset is asynchronous, active-high.
- Reset values: state IDLE; om_hready=1; om_hresp=OKAY; om_hrdata=0; all os_htrans=IDLE; capture registers=0.
- Reset mid-operation: return to IDLE immediately and drop any pending transfer. No response is owed.
- Decode:
  - sel_j = ((im_haddr or held addr) & SMASK_j) == SBASE_j.
  - When several paths match, the lowest index wins.
  - No match selects the default slave (index DEF).
- Sampling: a master address phase is sampled only when om_hready=1.
- NONSEQ/SEQ to mapped slave j:
  - Drive im_* combinationally onto os_* and put im_htrans on os_htrans[j].
  - If is_hready[j]=1: accepted; next state DATA(j).
  - If is_hready[j]=0: capture all address-phase signals; next state PEND(j).
- NONSEQ/SEQ to unmapped address: next state ERR1. Nothing is forwarded.
- IDLE: no data phase; om_hready=1, om_hresp=OKAY next cycle.
- BUSY: forwarded to the last selected path; no data phase. The block answers zero-wait OKAY.
- PEND(j):
  - om_hready=0.
  - Drive the captured address phase onto os_* and os_htrans[j] every cycle until is_hready[j]=1, then go to DATA(j).
  - im_* changes are ignored; the master is stalled by AHB rule.
- DATA(j):
  - om_hready=is_hready[j], om_hresp=is_hresp[j], om_hrdata=is_hrdata[j], all combinational.
  - When is_hready[j]=1, the data phase completes and the current im_* address phase is decoded in the same cycle (pipelined), applying the rules above.
  - A target k≠j is allowed.
  - A slave ERROR is passed through unchanged.
- ERR1: om_hready=0, om_hresp=ERROR. Next state ERR2.
- ERR2: om_hready=1, om_hresp=ERROR. The next address phase is sampled, as in DATA completion.
- om_hrdata outside DATA: 0.
- Latency: zero added wait states when the path is ready. PEND adds one cycle plus the path stall.

Decomposition:
- Package ehl_ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - state encoding IDLE/PEND/DATA/ERR1/ERR2.
- Sub-module ehl_ahb_addr_decoder: combinational address → one-hot SNUM select plus a no-match flag, parameterised by SNUM/SBASE/SMASK.

Test Plan:
- Zero-wait read: NONSEQ read to 0x1000_0004, slave 1 base 0x1000_0000, is_hready[1]=1 throughout, is_hrdata[1]=0xCAFE_0001 → os_htrans[3:2]=NONSEQ in cycle 0; om_hrdata=0xCAFE_0001, om_hready=1 in cycle 1.
- Pending path: NONSEQ write to slave 2 while is_hready[2]=0 for 3 cycles → om_hready=0 for 3 cycles; captured address stays on os_haddr; DATA follows; os_hwdata=im_hwdata=0x1234_5678 at completion.
- Unmapped: NONSEQ to 0xF000_0000 → om_hready=0/hresp=ERROR, then om_hready=1/hresp=ERROR; os_htrans all IDLE.
- Back-to-back across slaves: NONSEQ slave 0, then NONSEQ slave 3 presented during slave 0's data phase with is_hready[3]=1 → slave 3 address is issued in the cycle slave 0 completes; no bubble.
- Slave error pass-through plus mid-transfer reset: slave 0 returns hresp=ERROR with hready=0 then 1 → the master sees the same; hreset asserted during PEND → om_hready=1 and os_htrans=0 immediately.
